// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, trap
// cause codes, mstatus/mie/mip bit positions, the sequencer state enum and
// small address-classification helpers.
package csr_pkg;

  // CSR addresses (inst[31:20])
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Fixed ISA description: RV32 with the I base extension
  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // mcause encodings
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

  // Bit positions inside mstatus / mie / mip
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MEIE       = 11;
  localparam int MIP_MEIP       = 11;

  // Trap sequencer: RUN executes, REDIR is the single redirect bubble
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } csr_state_e;

  // True for every address this unit implements
  function automatic logic csr_addr_known(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
      CSR_MCYCLEH, CSR_MINSTRETH, CSR_MHARTID: csr_addr_known = 1'b1;
      default:                                  csr_addr_known = 1'b0;
    endcase
  endfunction

  // True for addresses where any write attempt is illegal
  function automatic logic csr_addr_read_only(input logic [11:0] addr);
    csr_addr_read_only = (addr == CSR_MISA) || (addr == CSR_MHARTID);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter built from two 32-bit halves. A software write to a
// half replaces it for that cycle and beats the increment; the carry into
// the upper half is only taken when the lower half is not being written.
module csr_counter64
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        carry;

  // Next-state: write wins over increment, carry suppressed by a low write
  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    carry = inc_i & (lo_q == 32'hFFFF_FFFF) & ~wr_lo_i;
    if (wr_lo_i) begin
      lo_d = wdata_i;
    end else if (inc_i) begin
      lo_d = lo_q + 32'd1;
    end
    if (wr_hi_i) begin
      hi_d = wdata_i;
    end else if (carry) begin
      hi_d = hi_q + 32'd1;
    end
  end

  // Counter halves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer.
// Executes csrrw/csrrs/csrrc (and immediate forms, pre-muxed into
// csr_wdata), takes ecall/ebreak/illegal-CSR traps, performs mret, and
// hands fetch a registered one-cycle redirect. Owns mcycle and minstret.
// Build option CSR_IRQ_EN: adds irq_ext, a writable mie.MEIE, a live
// mip.MEIP and machine external interrupt entry. Without it mie/mip read
// zero and writes to them are accepted and dropped.
//
// Handshake: there is no back-pressure. redirect_valid is a one-cycle
// pulse; fetch must load redirect_pc in the cycle it is seen. While it is
// high the unit is in REDIR and ignores instr_valid entirely.
module csr_unit
  import csr_pkg::*;
#(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   MTVEC_RESET = 32'h0000_0000,
  parameter int                HART_ID     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            is_csr,
  input  logic            csr_w,
  input  logic            csr_set,
  input  logic            csr_clr,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_src_zero,
  input  logic            is_mret,
  input  logic            exc_ecall,
  input  logic            exc_break,
`ifdef CSR_IRQ_EN
  input  logic            irq_ext,
`endif
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            dbg_state
);

  // Architectural state
  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]     mcycle, minstret;
`ifdef CSR_IRQ_EN
  logic            meie_q;
`endif

  // Sequencer and redirect
  csr_state_e      state_q, state_d;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  // Decode / control
  logic            write_attempt;
  logic            run_active;
  logic            irq_pending;
  logic            trap_take, mret_take;
  logic [XLEN-1:0] trap_cause, trap_tval;
  logic            csr_we, retire;
  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] mtvec_rd, mepc_rd;

  assign mtvec_rd = {mtvec_q[XLEN-1:2], 2'b00};
  assign mepc_rd  = {mepc_q[XLEN-1:2], 2'b00};

  // set/clr with a zero source only reads, so it never counts as a write
  assign write_attempt = csr_w | ((csr_set | csr_clr) & ~csr_src_zero);
  assign csr_illegal   = instr_valid & is_csr &
                         (~csr_addr_known(csr_addr) |
                          (write_attempt & csr_addr_read_only(csr_addr)));
  assign run_active    = instr_valid & (state_q == ST_RUN);

`ifdef CSR_IRQ_EN
  assign irq_pending = mstatus_mie_q & meie_q & irq_ext;
`else
  assign irq_pending = 1'b0;
`endif

  // Read mux: always the pre-write value of the addressed CSR
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        csr_rdata[MSTATUS_MPIE]                  = mstatus_mpie_q;
        csr_rdata[MSTATUS_MIE]                   = mstatus_mie_q;
      end
      CSR_MISA:      csr_rdata = MISA_VALUE;
`ifdef CSR_IRQ_EN
      CSR_MIE:       csr_rdata[MIE_MEIE] = meie_q;
      CSR_MIP:       csr_rdata[MIP_MEIP] = irq_ext;
`endif
      CSR_MTVEC:     csr_rdata = mtvec_rd;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_rd;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_MHARTID:   csr_rdata = XLEN'(HART_ID);
      default:       csr_rdata = '0;
    endcase
  end

  // Event selection in priority order: irq > illegal > ecall > ebreak > mret
  always_comb begin
    trap_take  = 1'b0;
    mret_take  = 1'b0;
    trap_cause = '0;
    trap_tval  = '0;
    if (run_active) begin
      if (irq_pending) begin
        trap_take  = 1'b1;
        trap_cause = CAUSE_MEI;
      end else if (csr_illegal) begin
        trap_take  = 1'b1;
        trap_cause = CAUSE_ILLEGAL;
      end else if (exc_ecall) begin
        trap_take  = 1'b1;
        trap_cause = CAUSE_ECALL_M;
      end else if (exc_break) begin
        trap_take  = 1'b1;
        trap_cause = CAUSE_BREAK;
        trap_tval  = pc;
      end else if (is_mret) begin
        mret_take  = 1'b1;
      end
    end
  end

  // A trapping instruction neither writes its CSR nor retires
  assign csr_we = run_active & is_csr & write_attempt & ~trap_take;
  assign retire = run_active & ~trap_take;

  // Read-modify-write value built from the pre-write read data
  always_comb begin
    wval = csr_wdata;
    if (csr_set) begin
      wval = csr_rdata | csr_wdata;
    end else if (csr_clr) begin
      wval = csr_rdata & ~csr_wdata;
    end
  end

  // mstatus interrupt-enable stack: trap pushes, mret pops, else software
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (trap_take) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_take) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (csr_we && csr_addr == CSR_MSTATUS) begin
      mstatus_mie_q  <= wval[MSTATUS_MIE];
      mstatus_mpie_q <= wval[MSTATUS_MPIE];
    end
  end

  // Trap CSRs: hardware trap entry overrides software writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_take) begin
      mepc_q   <= pc;
      mcause_q <= trap_cause;
      mtval_q  <= trap_tval;
    end else if (csr_we) begin
      if (csr_addr == CSR_MEPC)   mepc_q   <= wval;
      if (csr_addr == CSR_MCAUSE) mcause_q <= wval;
      if (csr_addr == CSR_MTVAL)  mtval_q  <= wval;
    end
  end

  // Plain software-owned CSRs (mtvec is direct mode only)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch_q <= '0;
    end else if (csr_we) begin
      if (csr_addr == CSR_MTVEC)    mtvec_q    <= {wval[XLEN-1:2], 2'b00};
      if (csr_addr == CSR_MSCRATCH) mscratch_q <= wval;
    end
  end

`ifdef CSR_IRQ_EN
  // External interrupt enable; the only implemented bit of mie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meie_q <= 1'b0;
    end else if (csr_we && csr_addr == CSR_MIE) begin
      meie_q <= wval[MIE_MEIE];
    end
  end
`endif

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && csr_addr == CSR_MCYCLE),
    .wr_hi_i (csr_we && csr_addr == CSR_MCYCLEH),
    .wdata_i (wval),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (retire),
    .wr_lo_i (csr_we && csr_addr == CSR_MINSTRET),
    .wr_hi_i (csr_we && csr_addr == CSR_MINSTRETH),
    .wdata_i (wval),
    .count_o (minstret)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state: any trap or mret costs exactly one REDIR cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (trap_take || mret_take) state_d = ST_REDIR;
      ST_REDIR: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Registered redirect to fetch, launched on the event edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= trap_take | mret_take;
      if (trap_take) begin
        redirect_pc_q <= mtvec_rd;
      end else if (mret_take) begin
        redirect_pc_q <= mepc_rd;
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit. A behavioural model (CSR values kept in
// an associative array, the interrupt-enable stack as two bits, minstret as
// a 64-bit integer) predicts read data, illegal flags and redirects.
module tb_csr_unit;

`ifdef CSR_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, is_csr, csr_w, csr_set, csr_clr, csr_src_zero;
  logic        is_mret, exc_ecall, exc_break, irq_ext;
  logic [31:0] pc, csr_wdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, redirect_pc;
  logic        csr_illegal, redirect_valid, dbg_state;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .is_csr         (is_csr),
    .csr_w          (csr_w),
    .csr_set        (csr_set),
    .csr_clr        (csr_clr),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_src_zero   (csr_src_zero),
    .is_mret        (is_mret),
    .exc_ecall      (exc_ecall),
    .exc_break      (exc_break),
`ifdef CSR_IRQ_EN
    .irq_ext        (irq_ext),
`endif
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dbg_state      (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_csr [logic [11:0]];
  logic        m_mie, m_mpie, m_meie, m_irq, m_redir;
  logic [63:0] m_instret;
  // model predictions and DUT samples for the latest cycle
  logic [31:0] e_rdata, e_rpc, s_rdata, s_rpc;
  logic        e_illegal, e_rv, s_illegal, s_rv;

  task automatic model_reset();
    m_csr[12'h305] = 32'h0; m_csr[12'h340] = 32'h0; m_csr[12'h341] = 32'h0;
    m_csr[12'h342] = 32'h0; m_csr[12'h343] = 32'h0;
    m_mie = 1'b0; m_mpie = 1'b0; m_meie = 1'b0;
    m_instret = 64'd0; m_redir = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: model_read = 32'h1800 | {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
      12'h301: model_read = 32'h4000_0100;
      12'h304: model_read = IRQ_EN ? {20'd0, m_meie, 11'd0} : 32'd0;
      12'h305, 12'h341: model_read = m_csr[a] & ~32'h3;
      12'h340, 12'h342, 12'h343: model_read = m_csr[a];
      12'h344: model_read = IRQ_EN ? {20'd0, m_irq, 11'd0} : 32'd0;
      12'hB02: model_read = m_instret[31:0];
      12'hB82: model_read = m_instret[63:32];
      default: model_read = 32'd0;
    endcase
  endfunction

  function automatic bit model_known(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14: model_known = 1'b1;
      default: model_known = 1'b0;
    endcase
  endfunction

  // Predict one cycle from the architectural rules, using pre-edge state
  task automatic model_step(input logic v, input logic [31:0] p, input logic csr,
                            input int op, input logic [11:0] a, input logic [31:0] wd,
                            input logic sz, input logic mr, input logic ec, input logic eb);
    logic wr, irq, trap;
    logic [31:0] nv, cause, tval;
    logic [63:0] ni;
    wr = (op == 0) || !sz;
    e_illegal = v & csr & (!model_known(a) | (wr & ((a == 12'h301) | (a == 12'hF14))));
    e_rdata = model_read(a);
    e_rv = 1'b0;
    if (m_redir) begin
      m_redir = 1'b0;
      return;
    end
    if (!v) return;
    irq  = IRQ_EN & m_mie & m_meie & m_irq;
    trap = irq | e_illegal | ec | eb;
    if (trap) begin
      if (irq)            begin cause = 32'h8000_000B; tval = 0; end
      else if (e_illegal) begin cause = 32'd2;  tval = 0; end
      else if (ec)        begin cause = 32'd11; tval = 0; end
      else                begin cause = 32'd3;  tval = p; end
      m_csr[12'h341] = p; m_csr[12'h342] = cause; m_csr[12'h343] = tval;
      m_mpie = m_mie; m_mie = 1'b0;
      e_rv = 1'b1; e_rpc = m_csr[12'h305] & ~32'h3; m_redir = 1'b1;
      return;
    end
    ni = m_instret + 64'd1;
    if (mr) begin
      e_rv = 1'b1; e_rpc = m_csr[12'h341] & ~32'h3; m_redir = 1'b1;
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (csr && wr) begin
      case (op)
        0:       nv = wd;
        1:       nv = e_rdata | wd;
        default: nv = e_rdata & ~wd;
      endcase
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: if (IRQ_EN) m_meie = nv[11];
        12'h305, 12'h340, 12'h341, 12'h342, 12'h343: m_csr[a] = nv;
        12'hB02: ni = {m_instret[63:32], nv};
        12'hB82: ni[63:32] = nv;
        default: ;
      endcase
    end
    m_instret = ni;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    instr_valid = 0; pc = 0; is_csr = 0; csr_w = 0; csr_set = 0; csr_clr = 0;
    csr_addr = 0; csr_wdata = 0; csr_src_zero = 0; is_mret = 0; exc_ecall = 0; exc_break = 0;
  endtask

  // One clock: drive, predict, sample combinational at negedge, registered after posedge
  task automatic cycle(input logic v, input logic [31:0] p, input logic csr, input int op,
                       input logic [11:0] a, input logic [31:0] wd, input logic sz,
                       input logic mr, input logic ec, input logic eb);
    instr_valid = v; pc = p; is_csr = csr;
    csr_w = csr && (op == 0); csr_set = csr && (op == 1); csr_clr = csr && (op == 2);
    csr_addr = a; csr_wdata = wd; csr_src_zero = sz;
    is_mret = mr; exc_ecall = ec; exc_break = eb;
    model_step(v, p, csr, op, a, wd, sz, mr, ec, eb);
    @(negedge clk);
    s_rdata = csr_rdata; s_illegal = csr_illegal;
    @(posedge clk); #1;
    s_rv = redirect_valid; s_rpc = redirect_pc;
    drive_idle();
  endtask

  task automatic csr_op(input int op, input logic [11:0] a, input logic [31:0] wd, input logic sz);
    cycle(1'b1, 32'h1000, 1'b1, op, a, wd, sz, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic csr_read(input logic [11:0] a);
    csr_op(1, a, 32'd0, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL reset_rv: got %b want 0", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'd0) $display("FAIL reset_rpc: got %h want 0", redirect_pc); else n_pass++;
    n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b want RUN", dbg_state); else n_pass++;
    release_reset();
    csr_read(12'h340);
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL reset_mscratch: got %h want 0", s_rdata); else n_pass++;
    csr_read(12'h300);
    n_checks++; if (s_rdata !== 32'h1800) $display("FAIL reset_mstatus: got %h want 1800", s_rdata); else n_pass++;
    csr_read(12'h301);
    n_checks++; if (s_rdata !== 32'h4000_0100) $display("FAIL misa: got %h want 40000100", s_rdata); else n_pass++;
    csr_read(12'hF14);
    n_checks++; if (s_rdata !== 32'd0 || s_illegal !== 1'b0) $display("FAIL mhartid_read: got %h ill %b want 0 ill 0", s_rdata, s_illegal); else n_pass++;
    csr_read(12'h305);
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL reset_mtvec: got %h want 0", s_rdata); else n_pass++;
  endtask

  task automatic test_rw_basic();
    csr_op(0, 12'h340, 32'hDEAD_BEEF, 1'b0);
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL rw_old: got %h want 0", s_rdata); else n_pass++;
    csr_read(12'h340);
    n_checks++; if (s_rdata !== 32'hDEAD_BEEF) $display("FAIL rw_read: got %h want deadbeef", s_rdata); else n_pass++;
    csr_op(2, 12'h340, 32'hFFFF_0000, 1'b0);
    n_checks++; if (s_rdata !== 32'hDEAD_BEEF) $display("FAIL clr_old: got %h want deadbeef", s_rdata); else n_pass++;
    csr_read(12'h340);
    n_checks++; if (s_rdata !== 32'h0000_BEEF) $display("FAIL clr_read: got %h want 0000beef", s_rdata); else n_pass++;
  endtask

  task automatic test_random_rw();
    logic [11:0] addrs [8];
    logic [11:0] a;
    int op;
    logic sz;
    logic [31:0] wd;
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h304, 12'hB02};
    for (int i = 0; i < 30; i++) begin
      a  = addrs[$urandom_range(0, 7)];
      op = $urandom_range(0, 2);
      sz = (op != 0) && ($urandom_range(0, 3) == 0);
      wd = sz ? 32'd0 : $urandom;
      csr_op(op, a, wd, sz);
      n_checks++;
      if (s_rdata !== e_rdata || s_illegal !== e_illegal || s_rv !== 1'b0)
        $display("FAIL rand_rw[%0d] addr %h: got %h ill %b rv %b want %h ill %b rv 0", i, a, s_rdata, s_illegal, s_rv, e_rdata, e_illegal);
      else n_pass++;
    end
  endtask

  task automatic test_trap_ecall();
    csr_op(0, 12'h305, 32'h100, 1'b0);
    csr_op(1, 12'h300, 32'h8, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (s_rv !== 1'b1 || s_rpc !== 32'h100) $display("FAIL ecall_redirect: got rv %b pc %h want 1 100", s_rv, s_rpc); else n_pass++;
    idle();
    n_checks++; if (s_rv !== 1'b0) $display("FAIL ecall_one_cycle: got rv %b want 0", s_rv); else n_pass++;
    csr_read(12'h341);
    n_checks++; if (s_rdata !== 32'h40) $display("FAIL ecall_mepc: got %h want 40", s_rdata); else n_pass++;
    csr_read(12'h342);
    n_checks++; if (s_rdata !== 32'd11) $display("FAIL ecall_mcause: got %h want b", s_rdata); else n_pass++;
    csr_read(12'h300);
    n_checks++; if (s_rdata !== 32'h1880) $display("FAIL ecall_mstatus: got %h want 1880", s_rdata); else n_pass++;
    cycle(1'b1, 32'h100, 1'b0, 0, 12'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (s_rv !== 1'b1 || s_rpc !== 32'h40) $display("FAIL mret_redirect: got rv %b pc %h want 1 40", s_rv, s_rpc); else n_pass++;
    idle();
    csr_read(12'h300);
    n_checks++; if (s_rdata !== 32'h1888) $display("FAIL mret_mstatus: got %h want 1888", s_rdata); else n_pass++;
  endtask

  task automatic test_ebreak_illegal();
    logic [31:0] scratch;
    cycle(1'b1, 32'h80, 1'b0, 0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (s_rv !== e_rv || s_rpc !== e_rpc) $display("FAIL ebreak_redirect: got rv %b pc %h want %b %h", s_rv, s_rpc, e_rv, e_rpc); else n_pass++;
    idle();
    csr_read(12'h342);
    n_checks++; if (s_rdata !== 32'd3) $display("FAIL ebreak_mcause: got %h want 3", s_rdata); else n_pass++;
    csr_read(12'h343);
    n_checks++; if (s_rdata !== 32'h80) $display("FAIL ebreak_mtval: got %h want 80", s_rdata); else n_pass++;
    scratch = m_csr[12'h340];
    cycle(1'b1, 32'h90, 1'b1, 0, 12'hF14, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (s_illegal !== 1'b1 || s_rv !== 1'b1) $display("FAIL hartid_write_illegal: got ill %b rv %b want 1 1", s_illegal, s_rv); else n_pass++;
    idle();
    csr_read(12'h342);
    n_checks++; if (s_rdata !== 32'd2) $display("FAIL illegal_mcause: got %h want 2", s_rdata); else n_pass++;
    csr_read(12'h343);
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL illegal_mtval: got %h want 0", s_rdata); else n_pass++;
    csr_read(12'h341);
    n_checks++; if (s_rdata !== 32'h90) $display("FAIL illegal_mepc: got %h want 90", s_rdata); else n_pass++;
    csr_read(12'hF14);
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL hartid_unchanged: got %h want 0", s_rdata); else n_pass++;
    csr_read(12'h340);
    n_checks++; if (s_rdata !== scratch) $display("FAIL illegal_scratch: got %h want %h", s_rdata, scratch); else n_pass++;
    csr_read(12'h7C0);
    n_checks++; if (s_illegal !== 1'b1 || s_rv !== 1'b1) $display("FAIL unknown_addr: got ill %b rv %b want 1 1", s_illegal, s_rv); else n_pass++;
    idle();
    csr_op(2, 12'h301, 32'd0, 1'b1);
    n_checks++; if (s_illegal !== 1'b0 || s_rdata !== 32'h4000_0100) $display("FAIL misa_clr_x0: got ill %b data %h want 0 40000100", s_illegal, s_rdata); else n_pass++;
  endtask

  task automatic test_counters();
    csr_op(0, 12'hB80, 32'd0, 1'b0);
    csr_op(0, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    idle();
    csr_read(12'hB80);
    n_checks++; if (s_rdata !== 32'd1) $display("FAIL mcycle_carry: got %h want 1", s_rdata); else n_pass++;
    csr_op(0, 12'hB00, 32'h1234, 1'b0);
    csr_read(12'hB00);
    n_checks++; if (s_rdata !== 32'h1234) $display("FAIL mcycle_write_wins: got %h want 1234", s_rdata); else n_pass++;
    csr_op(0, 12'hB02, 32'h50, 1'b0);
    csr_read(12'hB02);
    n_checks++; if (s_rdata !== 32'h50) $display("FAIL minstret_write_wins: got %h want 50", s_rdata); else n_pass++;
    csr_read(12'hB02);
    n_checks++; if (s_rdata !== 32'h51) $display("FAIL minstret_retire: got %h want 51", s_rdata); else n_pass++;
    csr_op(0, 12'hB02, 32'hFFFF_FFFF, 1'b0);
    csr_read(12'hB82);
    n_checks++; if (s_rdata !== e_rdata) $display("FAIL minstreth_pre: got %h want %h", s_rdata, e_rdata); else n_pass++;
    csr_read(12'hB82);
    n_checks++; if (s_rdata !== e_rdata) $display("FAIL minstreth_carry: got %h want %h", s_rdata, e_rdata); else n_pass++;
  endtask

  task automatic test_redir_ignore();
    logic [31:0] scratch, cause;
    csr_op(0, 12'hB02, 32'h100, 1'b0);
    scratch = m_csr[12'h340];
    cycle(1'b1, 32'h300, 1'b0, 0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (s_rv !== 1'b1) $display("FAIL redir_enter: got rv %b want 1", s_rv); else n_pass++;
    csr_op(0, 12'h340, 32'h1111_1111, 1'b0);
    n_checks++; if (s_rv !== 1'b0) $display("FAIL redir_no_new_event: got rv %b want 0", s_rv); else n_pass++;
    csr_read(12'hB02);
    n_checks++; if (s_rdata !== 32'h100) $display("FAIL redir_minstret: got %h want 100", s_rdata); else n_pass++;
    csr_read(12'h340);
    n_checks++; if (s_rdata !== scratch) $display("FAIL redir_no_write: got %h want %h", s_rdata, scratch); else n_pass++;
    cause = 32'd3;
    cycle(1'b1, 32'h310, 1'b0, 0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h314, 1'b1, 0, 12'hF14, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (s_illegal !== 1'b1 || s_rv !== 1'b0) $display("FAIL redir_no_trap: got ill %b rv %b want 1 0", s_illegal, s_rv); else n_pass++;
    csr_read(12'h342);
    n_checks++; if (s_rdata !== cause) $display("FAIL redir_mcause_kept: got %h want %h", s_rdata, cause); else n_pass++;
  endtask

  task automatic test_irq();
`ifdef CSR_IRQ_EN
    logic [31:0] scratch;
    csr_op(0, 12'h305, 32'h100, 1'b0);
    csr_op(1, 12'h300, 32'h8, 1'b0);
    csr_op(0, 12'h304, 32'h800, 1'b0);
    csr_op(0, 12'hB02, 32'h20, 1'b0);
    scratch = m_csr[12'h340];
    irq_ext = 1'b1; m_irq = 1'b1;
    cycle(1'b1, 32'h200, 1'b1, 0, 12'h340, 32'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (s_rv !== 1'b1 || s_rpc !== 32'h100) $display("FAIL irq_redirect: got rv %b pc %h want 1 100", s_rv, s_rpc); else n_pass++;
    idle();
    csr_read(12'h342);
    n_checks++; if (s_rdata !== 32'h8000_000B) $display("FAIL irq_mcause: got %h want 8000000b", s_rdata); else n_pass++;
    csr_read(12'h341);
    n_checks++; if (s_rdata !== 32'h200) $display("FAIL irq_mepc: got %h want 200", s_rdata); else n_pass++;
    csr_read(12'hB02);
    n_checks++; if (s_rdata !== 32'h20) $display("FAIL irq_minstret: got %h want 20", s_rdata); else n_pass++;
    csr_read(12'h340);
    n_checks++; if (s_rdata !== scratch) $display("FAIL irq_no_write: got %h want %h", s_rdata, scratch); else n_pass++;
    csr_read(12'h344);
    n_checks++; if (s_rdata !== 32'h800) $display("FAIL irq_mip: got %h want 800", s_rdata); else n_pass++;
    cycle(1'b1, 32'h204, 1'b0, 0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (s_rv !== 1'b0) $display("FAIL irq_masked: got rv %b want 0", s_rv); else n_pass++;
    irq_ext = 1'b0; m_irq = 1'b0;
`else
    csr_op(0, 12'h304, 32'h800, 1'b0);
    n_checks++; if (s_illegal !== 1'b0 || s_rv !== 1'b0) $display("FAIL mie_write_legal: got ill %b rv %b want 0 0", s_illegal, s_rv); else n_pass++;
    csr_read(12'h304);
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL mie_reads_zero: got %h want 0", s_rdata); else n_pass++;
    csr_read(12'h344);
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL mip_reads_zero: got %h want 0", s_rdata); else n_pass++;
`endif
  endtask

  task automatic test_reset_in_redir();
    csr_op(0, 12'h340, 32'h5A5A_5A5A, 1'b0);
    cycle(1'b1, 32'h500, 1'b0, 0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (s_rv !== 1'b1) $display("FAIL pre_reset_redirect: got rv %b want 1", s_rv); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || dbg_state !== 1'b0)
      $display("FAIL async_reset_redir: got rv %b pc %h st %b want 0 0 0", redirect_valid, redirect_pc, dbg_state);
    else n_pass++;
    model_reset();
    release_reset();
    csr_read(12'h340);
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL post_reset_scratch: got %h want 0", s_rdata); else n_pass++;
    csr_read(12'h300);
    n_checks++; if (s_rdata !== 32'h1800) $display("FAIL post_reset_mstatus: got %h want 1800", s_rdata); else n_pass++;
  endtask

  initial begin
    irq_ext = 1'b0; m_irq = 1'b0;
    test_reset();
    test_rw_basic();
    test_random_rw();
    test_trap_ecall();
    test_ebreak_illegal();
    test_counters();
    test_redir_ignore();
    test_irq();
    test_reset_in_redir();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
